// File: rtl/load_issue_queue.sv
// Circular load queue between execute and the dcache port. It issues the oldest
// load whenever the dcache can take one, and a flush discards every entry.
module load_issue_queue #(
  parameter int LQ_DEPTH    = 8,
  parameter int LQ_PTR_BITS = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ex_ld_valid,
  input  logic [63:0]            ex_ld_addr,
  input  logic [6:0]             ex_ld_pr,
  input  logic [4:0]             ex_ld_ar,
  input  logic                   lsq_load_avail,
  input  logic                   lq_flush,
  output logic                   lsq_rd_mem,
  output logic [63:0]            proc2Dcache_addr,
  output logic [6:0]             lsq_pr,
  output logic [4:0]             lsq_ar,
  output logic                   lq_full,
  output logic [LQ_PTR_BITS:0]   lq_count,
  output logic                   lq_overflow
);

  typedef struct packed {
    logic [63:0] addr;
    logic [6:0]  pr;
    logic [4:0]  ar;
  } lq_entry_t;

  localparam logic [LQ_PTR_BITS:0]   C_DEPTH   = (LQ_PTR_BITS+1)'(LQ_DEPTH);
  localparam logic [LQ_PTR_BITS:0]   C_CNT_ONE = (LQ_PTR_BITS+1)'(1);
  localparam logic [LQ_PTR_BITS-1:0] C_PTR_ONE = LQ_PTR_BITS'(1);

  lq_entry_t              r_mem [LQ_DEPTH];
  logic [LQ_PTR_BITS-1:0] r_head;
  logic [LQ_PTR_BITS-1:0] r_tail;
  logic [LQ_PTR_BITS:0]   r_count;
  logic                   r_overflow;

  logic      w_empty;
  logic      w_full;
  logic      w_push;
  logic      w_pop;
  lq_entry_t w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_head  = r_mem[r_head];

  // A push is judged against the occupancy before this edge, so a full queue
  // rejects it even when the head pops in the same cycle.
  assign w_push = ex_ld_valid & ~w_full & ~lq_flush;
  assign w_pop  = lsq_rd_mem;

  assign lsq_rd_mem       = ~w_empty & lsq_load_avail & ~lq_flush;
  assign proc2Dcache_addr = w_empty ? '0 : w_head.addr;
  assign lsq_pr           = w_empty ? '0 : w_head.pr;
  assign lsq_ar           = w_empty ? '0 : w_head.ar;
  assign lq_full          = w_full;
  assign lq_count         = r_count;
  assign lq_overflow      = r_overflow;

  // NOTE: non-blocking assignments throughout, so every register samples
  // pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      // NOTE: the entry storage is reset as well, so a just-reset queue
      // never holds stale loads; this costs flops instead of a RAM macro.
      for (int i = 0; i < LQ_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (ex_ld_valid && w_full) begin
        r_overflow <= 1'b1;
      end
      if (lq_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_tail] <= '{addr: ex_ld_addr, pr: ex_ld_pr, ar: ex_ld_ar};
          r_tail        <= r_tail + C_PTR_ONE;
        end
        if (w_pop) begin
          r_head <= r_head + C_PTR_ONE;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + C_CNT_ONE;
          2'b01:   r_count <= r_count - C_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_issue_queue.sv
// Scoreboard bench for load_issue_queue: the driver keeps a queue model of the
// accepted loads, and a negedge monitor pops and compares each issued load.
module tb_load_issue_queue;

  localparam int DEPTH = 8;
  localparam int PB    = 3;

  logic        clock;
  logic        reset;
  logic        ex_ld_valid;
  logic [63:0] ex_ld_addr;
  logic [6:0]  ex_ld_pr;
  logic [4:0]  ex_ld_ar;
  logic        lsq_load_avail;
  logic        lq_flush;
  logic        lsq_rd_mem;
  logic [63:0] proc2Dcache_addr;
  logic [6:0]  lsq_pr;
  logic [4:0]  lsq_ar;
  logic        lq_full;
  logic [PB:0] lq_count;
  logic        lq_overflow;

  load_issue_queue #(.LQ_DEPTH(DEPTH), .LQ_PTR_BITS(PB)) dut (
    .clock            (clock),
    .reset            (reset),
    .ex_ld_valid      (ex_ld_valid),
    .ex_ld_addr       (ex_ld_addr),
    .ex_ld_pr         (ex_ld_pr),
    .ex_ld_ar         (ex_ld_ar),
    .lsq_load_avail   (lsq_load_avail),
    .lq_flush         (lq_flush),
    .lsq_rd_mem       (lsq_rd_mem),
    .proc2Dcache_addr (proc2Dcache_addr),
    .lsq_pr           (lsq_pr),
    .lsq_ar           (lsq_ar),
    .lq_full          (lq_full),
    .lq_count         (lq_count),
    .lq_overflow      (lq_overflow)
  );

  typedef struct {
    logic [63:0] addr;
    logic [6:0]  pr;
    logic [4:0]  ar;
  } ent_t;

  ent_t exp_q[$];
  ent_t pend_entry;
  bit   pend_push, pend_flush, pend_ovf, model_ovf;
  int   n_checks = 0;
  int   n_err    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic commit();
    if (pend_flush) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_entry);
    if (pend_ovf) model_ovf = 1'b1;
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    pend_ovf   = 1'b0;
  endtask

  // One clock of stimulus; the model decision uses occupancy before the edge.
  task automatic cycle(input bit v, input logic [63:0] a, input logic [6:0] p,
                       input logic [4:0] r, input bit av, input bit fl);
    @(posedge clock);
    commit();
    #1;
    ex_ld_valid    = v;
    ex_ld_addr     = a;
    ex_ld_pr       = p;
    ex_ld_ar       = r;
    lsq_load_avail = av;
    lq_flush       = fl;
    pend_entry     = '{addr: a, pr: p, ar: r};
    pend_push      = v && !fl && (exp_q.size() < DEPTH);
    pend_flush     = fl;
    pend_ovf       = v && (exp_q.size() == DEPTH);
  endtask

  task automatic idle(input bit av);
    cycle(1'b0, 64'h0, 7'h0, 5'h0, av, 1'b0);
  endtask

  task automatic push(input logic [63:0] a, input bit av);
    cycle(1'b1, a, 7'($urandom), 5'($urandom), av, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_mem"}, 64'(lsq_rd_mem), 64'd0);
    check({tag, "_addr"},   proc2Dcache_addr, 64'd0);
    check({tag, "_pr"},     64'(lsq_pr), 64'd0);
    check({tag, "_ar"},     64'(lsq_ar), 64'd0);
    check({tag, "_full"},   64'(lq_full), 64'd0);
    check({tag, "_count"},  64'(lq_count), 64'd0);
    check({tag, "_ovf"},    64'(lq_overflow), 64'd0);
  endtask

  // Asserts reset mid-cycle with traffic still applied; outputs must clear at once.
  task automatic apply_reset_mid();
    @(posedge clock);
    commit();
    #1;
    check("pre_reset_count", 64'(lq_count), 64'(exp_q.size()));
    #1;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    exp_q.delete();
    model_ovf      = 1'b0;
    pend_push      = 1'b0;
    pend_flush     = 1'b0;
    pend_ovf       = 1'b0;
    ex_ld_valid    = 1'b0;
    lsq_load_avail = 1'b0;
    lq_flush       = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: each negedge, compare what the DUT presents against the model.
  initial begin
    ent_t e;
    bit   exp_rd;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_rd = (exp_q.size() != 0) && lsq_load_avail && !lq_flush;
        check("rd_mem",   64'(lsq_rd_mem), 64'(exp_rd));
        check("count",    64'(lq_count), 64'(exp_q.size()));
        check("full",     64'(lq_full), 64'(exp_q.size() == DEPTH));
        check("overflow", 64'(lq_overflow), 64'(model_ovf));
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("head_addr", proc2Dcache_addr, e.addr);
          check("head_pr",   64'(lsq_pr), 64'(e.pr));
          check("head_ar",   64'(lsq_ar), 64'(e.ar));
        end else begin
          check("empty_addr", proc2Dcache_addr, 64'd0);
          check("empty_pr",   64'(lsq_pr), 64'd0);
          check("empty_ar",   64'(lsq_ar), 64'd0);
        end
        if (exp_rd) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    ex_ld_valid    = 1'b0;
    ex_ld_addr     = '0;
    ex_ld_pr       = '0;
    ex_ld_ar       = '0;
    lsq_load_avail = 1'b0;
    lq_flush       = 1'b0;
    pend_push      = 1'b0;
    pend_flush     = 1'b0;
    pend_ovf       = 1'b0;
    model_ovf      = 1'b0;
    #3;
    check_outputs_zero("reset");
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;

    // Single load: not presentable in its push cycle, issues the next.
    cycle(1'b1, 64'h1000, 7'd12, 5'd3, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill to full, overflow on the ninth push, then drain in order.
    for (int i = 0; i < 8; i++) push(64'(i * 8), 1'b0);
    push(64'h40, 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // Full queue with push and pop in the same cycle: push is rejected.
    for (int i = 0; i < 8; i++) push(64'h100 + 64'(i * 8), 1'b0);
    push(64'h900, 1'b1);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // Steady occupancy of three while the pointers wrap.
    for (int i = 0; i < 3; i++) push(64'h3000 + 64'(i), 1'b0);
    for (int i = 0; i < 12; i++) push(64'h4000 + 64'(i), 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Flush overrides a coincident push and pop.
    for (int i = 0; i < 5; i++) push(64'h5000 + 64'(i), 1'b0);
    cycle(1'b1, 64'h5555, 7'd1, 5'd1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset in the middle of a burst, then a fresh load lands at entry 0.
    for (int i = 0; i < 4; i++) push(64'h6000 + 64'(i), 1'b0);
    push(64'h6100, 1'b1);
    apply_reset_mid();
    cycle(1'b1, 64'h2000, 7'd5, 5'd7, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), {$urandom, $urandom}, 7'($urandom), 5'($urandom),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 3));
    end
    for (int i = 0; i < 10; i++) idle(1'b1);
    @(negedge clock);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/load_issue_queue.md
LOAD_ISSUE_QUEUE -- requirements
Module: load_issue_queue

Interface
REQ-001 SHALL have parameter LQ_DEPTH, default 8, number of load entries (power of two, 2..16).
REQ-002 SHALL have parameter LQ_PTR_BITS, default 3, log2(LQ_DEPTH).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ex_ld_valid  input  1  execute stage presents a load this cycle.
REQ-006 SHALL have port ex_ld_addr  input  64  effective load address.
REQ-007 SHALL have port ex_ld_pr  input  7  destination physical register.
REQ-008 SHALL have port ex_ld_ar  input  5  destination architectural register.
REQ-009 SHALL have port lsq_load_avail  input  1  dcache can accept a load this cycle.
REQ-010 SHALL have port lq_flush  input  1  branch-mispredict recovery; discard all entries.
REQ-011 SHALL have port lsq_rd_mem  output  1  load presented to dcache this cycle.
REQ-012 SHALL have port proc2Dcache_addr  output  64  address of the head load.
REQ-013 SHALL have port lsq_pr  output  7  head load physical register.
REQ-014 SHALL have port lsq_ar  output  5  head load architectural register.
REQ-015 SHALL have port lq_full  output  1  queue holds LQ_DEPTH entries.
REQ-016 SHALL have port lq_count  output  LQ_PTR_BITS+1  current occupancy.
REQ-017 SHALL have port lq_overflow  output  1  sticky; push attempted while full.

Function
REQ-018 SHALL store entries {addr, pr, ar} in a circular FIFO with head, tail (LQ_PTR_BITS each) and count registers.
REQ-019 SHALL accept a push when ex_ld_valid=1 and lq_full=0: write entry at tail, tail wraps from LQ_DEPTH-1 to 0.
REQ-020 SHALL reject a push when lq_full=1, even if a pop occurs the same cycle; entry state unchanged, lq_overflow set to 1.
REQ-021 SHALL drive lsq_rd_mem = (count!=0) & lsq_load_avail & ~lq_flush, combinationally.
REQ-022 SHALL drive proc2Dcache_addr/lsq_pr/lsq_ar from the head entry when count!=0, else all zero.
REQ-023 SHALL pop the head at the clock edge where lsq_rd_mem=1 (hit or miss; dcache owns the load thereafter); head wraps like tail.
REQ-024 SHALL update count: +1 push only, -1 pop only, unchanged on push+pop or neither.
REQ-025 SHALL not bypass: a load pushed into an empty queue is presentable to dcache no earlier than the following cycle.
REQ-026 SHALL, on lq_flush=1, set head=tail=count=0 at the next edge; flush overrides push and pop that cycle; lq_overflow is not cleared by flush.
REQ-027 SHALL derive lq_full = (count==LQ_DEPTH) and lq_count = count, both from registered state.
REQ-028 SHALL preserve FIFO order; issue order equals accept order.

Reset
REQ-029 SHALL, while reset=1 (asynchronously), force head=0, tail=0, count=0, lq_overflow=0 and all entry fields to 0.
REQ-030 SHALL therefore hold lsq_rd_mem=0, proc2Dcache_addr=0, lsq_pr=0, lsq_ar=0, lq_full=0, lq_count=0 during reset.
REQ-031 SHALL discard any in-flight push or pop coincident with reset assertion; first accepted push after release lands in entry 0.

Verification
REQ-032 SHALL cover: reset, push {addr=0x1000,pr=12,ar=3}, lsq_load_avail=1 -> next cycle lsq_rd_mem=1, addr 0x1000, pr 12, ar 3; following cycle count=0, lsq_rd_mem=0.
REQ-033 SHALL cover: lsq_load_avail=0, 8 pushes addr 0x0,0x8..0x38 -> lq_full=1, lq_count=8; 9th push -> lq_overflow=1, count stays 8; then avail=1 -> issues 0x0..0x38 in order over 8 cycles.
REQ-034 SHALL cover: full queue, push and pop same cycle -> push rejected, count=7, lq_overflow=1.
REQ-035 SHALL cover: 12 push/pop pairs with count held at 3 -> pointers wrap past 7, issue order intact, count stays 3.
REQ-036 SHALL cover: count=5, lq_flush=1 with ex_ld_valid=1 and lsq_load_avail=1 -> lsq_rd_mem=0 that cycle, next cycle count=0, lq_full=0.
REQ-037 SHALL cover: reset asserted mid-burst with count=4 -> all outputs 0 immediately without a clock edge; after release a push of 0x2000 issues as head.
